// File: rtl/sqrt_iter.sv
// Iterative radix-4 integer square root: root = floor(sqrt(a)), rem = a - root^2.
// Optional single-cycle alignment via leading-one detect when SQRT_FAST_ALIGN_EN is defined.
module sqrt_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIDTH-1:0]   a_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [WIDTH/2-1:0] root_o,
  output logic [WIDTH/2:0]   rem_o
);

  localparam int unsigned RW = WIDTH / 2;
  localparam logic [WIDTH-1:0] D_INIT = {2'b01, {(WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, ALIGN, ITER} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [RW-1:0]    root_q, root_d;
  logic [RW:0]      rem_q, rem_d;
  logic [WIDTH-1:0] rd;

  assign rd = r_q + d_q;

`ifdef SQRT_FAST_ALIGN_EN
  logic [WIDTH-1:0] pow4;

  // Highest power of four not exceeding x; zero when x is zero.
  always_comb begin
    pow4 = '0;
    for (int unsigned i = 0; i < WIDTH; i += 2) begin
      if (((x_q >> i) & WIDTH'(3)) != '0) pow4 = WIDTH'(1) << i;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    d_d     = d_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = a_i;
          r_d     = '0;
          d_d     = D_INIT;
          busy_d  = 1'b1;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (abort_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
`ifdef SQRT_FAST_ALIGN_EN
          d_d     = pow4;
          state_d = ITER;
`else
          if (d_q > x_q && d_q != '0) d_d = d_q >> 2;
          else                        state_d = ITER;
`endif
        end
      end
      ITER: begin
        if (abort_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (d_q != '0) begin
          d_d = d_q >> 2;
          if (x_q >= rd) begin
            x_d = x_q - rd;
            r_d = (r_q >> 1) + d_q;
          end else begin
            r_d = r_q >> 1;
          end
        end else begin
          root_d  = r_q[RW-1:0];
          rem_d   = x_q[RW:0];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      r_q     <= '0;
      d_q     <= D_INIT;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      r_q     <= r_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign root_o  = root_q;
  assign rem_o   = rem_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: directed WIDTH=32 scenarios plus a randomized WIDTH=8 sweep.
// Latency is counted as the edge index (accept edge = 0) at which valid_o is sampled high.
module tb_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, abort32;
  logic [31:0] a32;
  logic        busy32, valid32;
  logic [15:0] root32;
  logic [16:0] rem32;
  logic        start8, abort8;
  logic [7:0]  a8;
  logic        busy8, valid8;
  logic [3:0]  root8;
  logic [4:0]  rem8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sqrt_iter #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .abort_i(abort32), .a_i(a32),
    .busy_o(busy32), .valid_o(valid32), .root_o(root32), .rem_o(rem32)
  );

  sqrt_iter #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .abort_i(abort8), .a_i(a8),
    .busy_o(busy8), .valid_o(valid8), .root_o(root8), .rem_o(rem8)
  );

  function automatic longint unsigned ref_root(input longint unsigned a, input int w);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = w / 2 - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= a) r = t;
    end
    return r;
  endfunction

  function automatic int exp_lat(input longint unsigned a, input int w);
`ifdef SQRT_FAST_ALIGN_EN
    int steps = 0;
    longint unsigned v = a;
    while (v != 0) begin
      v = v / 4;
      steps++;
    end
    return steps + 3;
`else
    return w / 2 + 3;
`endif
  endfunction

  task automatic start_op32(input logic [31:0] a);
    start32 = 1'b1;
    a32     = a;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    a32     = $urandom;
  endtask

  // kind: 0 none, 1 extra start with a=4, 2 abort; injection sampled at edge inj_at.
  task automatic run32(input int inj_at, input int kind, output bit seen, output int lat,
                       output logic busy_acc, output logic busy_inj);
    int elapsed = 0;
    seen = 0; lat = 0; busy_acc = 1'bx; busy_inj = 1'bx;
    while (!seen && elapsed < 26) begin
      if (kind == 1 && elapsed == inj_at - 1) begin start32 = 1'b1; a32 = 32'd4; end
      if (kind == 2 && elapsed == inj_at - 1) abort32 = 1'b1;
      @(negedge clk);
      if (elapsed == 0) busy_acc = busy32;
      if (elapsed == inj_at) busy_inj = busy32;
      if (valid32) begin
        seen = 1;
        lat  = elapsed + 1;
      end else begin
        @(posedge clk);
        #1;
        start32 = 1'b0;
        abort32 = 1'b0;
        elapsed++;
      end
    end
  endtask

  task automatic check_result32(input string name, input longint unsigned a);
    bit seen; int lat; logic ba, bi;
    longint unsigned er, em;
    er = ref_root(a, 32);
    em = a - er * er;
    run32(-10, 0, seen, lat, ba, bi);
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: no valid_o within budget, required latency %0d", name, exp_lat(a, 32));
      return;
    end
    tests++;
    if (lat !== exp_lat(a, 32)) begin
      fails++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(a, 32));
    end
    tests++;
    if (longint'(root32) !== er || longint'(rem32) !== em) begin
      fails++;
      $display("FAIL %s result a=%0d: got root=%0d rem=%0d expected root=%0d rem=%0d",
               name, a, root32, rem32, er, em);
    end
    tests++;
    if (ba !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_accept: got %b expected 1", name, ba);
    end
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if (busy32 !== 1'b0 || valid32 !== 1'b0 || root32 !== 16'd0 || rem32 !== 17'd0) begin
      fails++;
      $display("FAIL reset32: got busy=%b valid=%b root=%0d rem=%0d expected all 0",
               busy32, valid32, root32, rem32);
    end
    tests++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0 || root8 !== 4'd0 || rem8 !== 5'd0) begin
      fails++;
      $display("FAIL reset8: got busy=%b valid=%b root=%0d rem=%0d expected all 0",
               busy8, valid8, root8, rem8);
    end
    #9 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    longint unsigned v;
    start_op32(32'd16);         check_result32("a16", 16);
    @(negedge clk); start_op32(32'd15); check_result32("a15", 15);
    @(negedge clk); start_op32(32'd0);  check_result32("a0", 0);
    @(negedge clk); start_op32(32'hFFFF_FFFF); check_result32("a_ones", 64'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      v = longint'($urandom) >> ($urandom_range(0, 31));
      @(negedge clk);
      start_op32(v[31:0]);
      check_result32("rand32", v);
    end
  endtask

  task automatic test_back_to_back;
    bit seen; int lat; logic ba, bi;
    @(negedge clk);
    start_op32(32'd1000000);
    run32(5, 1, seen, lat, ba, bi);
    tests++;
    if (!seen || lat !== exp_lat(1000000, 32) || root32 !== 16'd1000 || rem32 !== 17'd0) begin
      fails++;
      $display("FAIL start_while_busy: got seen=%0d lat=%0d root=%0d rem=%0d expected lat=%0d root=1000 rem=0",
               seen, lat, root32, rem32, exp_lat(1000000, 32));
    end
    // Still in the valid_o cycle: this start must be accepted.
    start_op32(32'd2);
    check_result32("start_in_valid_cycle", 2);
  endtask

  task automatic test_abort;
    bit seen; int lat; logic ba, bi;
    int cl;
    @(negedge clk);
    start_op32(32'd99);
    run32(4, 2, seen, lat, ba, bi);
    tests++;
    if (seen || bi !== 1'b0 || root32 !== 16'd1 || rem32 !== 17'd1) begin
      fails++;
      $display("FAIL abort_mid: got seen=%0d busy=%b root=%0d rem=%0d expected seen=0 busy=0 root=1 rem=1",
               seen, bi, root32, rem32);
    end
    cl = exp_lat(99, 32);
    @(negedge clk);
    start_op32(32'd99);
    run32(cl - 1, 2, seen, lat, ba, bi);
    tests++;
    if (seen || bi !== 1'b0 || root32 !== 16'd1 || rem32 !== 17'd1) begin
      fails++;
      $display("FAIL abort_at_completion: got seen=%0d busy=%b root=%0d rem=%0d expected seen=0 busy=0 root=1 rem=1",
               seen, bi, root32, rem32);
    end
    @(negedge clk);
    start_op32(32'd81);
    check_result32("after_abort", 81);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start_op32(32'd500);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if (busy32 !== 1'b0 || valid32 !== 1'b0 || root32 !== 16'd0 || rem32 !== 17'd0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b valid=%b root=%0d rem=%0d expected all 0",
               busy32, valid32, root32, rem32);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_op32(32'd500);
    check_result32("a500_after_reset", 500);
  endtask

  task automatic test_sweep8;
    int order [256];
    int j, t, elapsed, lat;
    bit seen;
    longint unsigned a, er, r;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      a = longint'(order[i]);
      start8 = 1'b1;
      a8 = a[7:0];
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8 = 8'($urandom);
      elapsed = 0; seen = 0; lat = 0;
      while (!seen && elapsed < 20) begin
        @(negedge clk);
        if (valid8) begin
          seen = 1;
          lat  = elapsed + 1;
        end else begin
          @(posedge clk);
          #1;
          elapsed++;
        end
      end
      er = ref_root(a, 8);
      r  = longint'(root8);
      tests++;
      if (!seen || lat !== exp_lat(a, 8)) begin
        fails++;
        $display("FAIL sweep8_latency a=%0d: got seen=%0d lat=%0d expected %0d", a, seen, lat, exp_lat(a, 8));
      end
      tests++;
      if (r !== er || longint'(rem8) !== a - er * er || r * r > a || (r + 1) * (r + 1) <= a) begin
        fails++;
        $display("FAIL sweep8_result a=%0d: got root=%0d rem=%0d expected root=%0d rem=%0d",
                 a, root8, rem8, er, a - er * er);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start32 = 1'b0; abort32 = 1'b0; a32 = '0;
    start8 = 1'b0; abort8 = 1'b0; a8 = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_sweep8;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sqrt_iter.md
Name: sqrt_iter

Overview:
Parametrised, restartable iterative integer square-root unit; successor to the fixed 32-bit sqrt block.
- Computes root = floor(sqrt(a)) and remainder = a - root^2 for a WIDTH-bit unsigned operand.
- Uses the radix-4 digit-by-digit method: align, then one result bit per cycle.
- Adds a remainder output, abort, held result registers and a fixed, width-derived latency.
- Sits beside the datapath as a multi-cycle slave controlled by a start/valid handshake.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4; root width RW = WIDTH/2.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  request; accepted only while busy_o=0
abort_i  in  1  cancel an operation in progress
a_i  in  WIDTH  operand, sampled in the accept cycle only
busy_o  out  1  operation in progress (registered)
valid_o  out  1  one-cycle pulse: results updated
root_o  out  RW  floor(sqrt(a)), held until next completion
rem_o  out  RW+1  a - root^2 (max 2*root), held until next completion

Behaviour:
- Reset values: busy_o=0, valid_o=0, root_o=0, rem_o=0; state IDLE; internal x=0, r=0, d=1<<(WIDTH-2).
- Reset mid-operation: operation discarded, all outputs return to reset values.
- States: IDLE, ALIGN, ITER. All outputs are registered.
- IDLE: if start_i, then x<=a_i, r<=0, d<=1<<(WIDTH-2), busy<=1, go to ALIGN. abort_i is ignored in IDLE.
- ALIGN: if d>x and d!=0, then d<=d>>2. Otherwise go to ITER with no datapath change.
- ITER, d!=0: d<=d>>2.
  - If x >= r+d: x<=x-(r+d), r<=(r>>1)+d.
  - Else: r<=r>>1.
- ITER, d==0: root_o<=r[RW-1:0], rem_o<=x[RW:0], valid_o<=1 for exactly one cycle, busy<=0, go to IDLE.
- Internal x, r, d are WIDTH bits wide. r+d cannot overflow for legal operands.
- Latency: valid_o is high exactly WIDTH/2+3 clock edges after the accept edge, for every operand including 0 and all-ones. busy_o is high from accept+1 through the completion edge.
- start_i while busy_o=1: ignored, with no effect on the running operation.
- start_i in the cycle valid_o=1: accepted, since state is IDLE. Back-to-back throughput is one result per WIDTH/2+3 cycles.
- abort_i in ALIGN or ITER: next edge goes to IDLE, busy_o<=0, valid_o stays 0, root_o/rem_o keep their previous values.
- abort_i and the completing ITER cycle (d==0) together: abort wins; no valid pulse, outputs unchanged.
- a_i may change freely after the accept cycle.

Optional Feature:
SQRT_FAST_ALIGN_EN.
- Defined: ALIGN lasts exactly one cycle. d<= the highest power of 4 <= x, computed with a leading-one detect on x; if x==0, d<=0. Then go to ITER. Latency becomes I+3 edges, where I = number of ITER steps (floor(log4(a))+1, 0 for a=0).
- Undefined: iterative ALIGN as above, with fixed WIDTH/2+3 latency.
- Results are identical in both builds.

Test Plan:
1. WIDTH=32, reset, start a=16 -> root_o=4, rem_o=0, valid_o pulses 19 edges after accept; with SQRT_FAST_ALIGN_EN, 6 edges.
2. a=15 -> root 3, rem 6. a=0 -> root 0, rem 0, 19 edges (3 with fast align). a=0xFFFFFFFF -> root 65535, rem 131070.
3. Start a=1000000, pulse start_i again with a=4 at accept+5 -> ignored; result root 1000, rem 0. Then start a=2 in the valid cycle -> accepted; root 1, rem 1.
4. After case 3, start a=99 and assert abort_i at accept+4 -> busy_o falls next edge, no valid pulse, root_o=1/rem_o=1 unchanged. Abort coincident with the completion cycle -> no valid pulse.
5. Assert rst_i at accept+7 of a=500 -> all outputs 0 asynchronously. After release, a=500 -> root 22, rem 16.
6. WIDTH=8, random sweep 0..255 against a reference model -> root^2 <= a < (root+1)^2 and rem == a-root^2 for every value; latency 7 edges (iterative build).
